// File: rtl/fp_muldiv_seq_ctrl.sv
// Sequential fp multiply / divide controller.
// One op in flight: classify, iterate mantissa core, normalise, pack.
module fp_muldiv_seq_ctrl #(
    parameter int MB = 23,
    parameter int EB = 8,
    localparam int N = MB + EB + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic [4:0]   flags_o
);

    localparam int BIAS = 2 ** (EB - 1) - 1;
    localparam int EW   = EB + 2;
    localparam int PW   = 2 * MB + 2;
    localparam int MW   = MB + 1;
    localparam int QW   = MB + 2;
    localparam int CW   = $clog2(QW + 1);

    localparam logic [CW-1:0]        KMUL   = CW'(MW - 1);
    localparam logic [CW-1:0]        KDIV   = CW'(QW - 1);
    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX   = EW'(2 ** EB - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ITER, S_NORM, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                 op_q;
    logic [N-1:0]         a_q, b_q;
    logic                 sign_q;
    logic signed [EW-1:0] exp_q;
    logic                 spec_q;
    logic [N-1:0]         spec_res_q;
    logic [4:0]           flg_q;
    logic [PW-1:0]        acc_q;
    logic [PW-1:0]        mcnd_q;
    logic [QW-1:0]        qm_q;
    logic [MW-1:0]        dvs_q;
    logic [CW-1:0]        cnt_q;

    // Operand fields and classes (denormals count as zero: flushed)
    logic [EB-1:0] ea, eb;
    logic [MB-1:0] fa, fb;
    logic          a_den, b_den, a_zero, b_zero;
    logic          a_inf, b_inf, a_nan, b_nan;
    logic [MW-1:0] ma, mb;
    logic          ld_sign;
    logic signed [EW-1:0] ea_s, eb_s, ld_exp;

    assign ea     = a_q[N-2:MB];
    assign eb     = b_q[N-2:MB];
    assign fa     = a_q[MB-1:0];
    assign fb     = b_q[MB-1:0];
    assign a_den  = (ea == '0) && (fa != '0);
    assign b_den  = (eb == '0) && (fb != '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);
    assign ma     = {1'b1, fa};
    assign mb     = {1'b1, fb};
    assign ld_sign = a_q[N-1] ^ b_q[N-1];
    assign ea_s   = $signed({2'b00, ea});
    assign eb_s   = $signed({2'b00, eb});
    assign ld_exp = op_q ? (ea_s - eb_s + BIAS_E)
                         : (ea_s + eb_s - BIAS_E);

    // Special-case detection in priority order
    logic         ld_spec;
    logic [N-1:0] ld_res;
    logic [4:0]   ld_flg;

    // Classify operands into a special result when the core is not needed
    always_comb begin
        ld_spec = 1'b1;
        ld_res  = '0;
        ld_flg  = {4'b0000, a_den | b_den};
        if (a_nan || b_nan ||
            (!op_q && ((a_inf && b_zero) || (a_zero && b_inf))) ||
            (op_q && a_zero && b_zero) ||
            (op_q && a_inf && b_inf)) begin
            ld_res    = {1'b0, {(N-1){1'b1}}};
            ld_flg[4] = 1'b1;
        end else if (op_q && b_zero) begin
            ld_res    = {ld_sign, {EB{1'b1}}, {MB{1'b0}}};
            ld_flg[3] = 1'b1;
        end else if ((!op_q && (a_inf || b_inf)) || (op_q && a_inf)) begin
            ld_res = {ld_sign, {EB{1'b1}}, {MB{1'b0}}};
        end else if ((!op_q && (a_zero || b_zero)) ||
                     (op_q && (a_zero || b_inf))) begin
            ld_res = {ld_sign, {(N-1){1'b0}}};
        end else begin
            ld_spec = 1'b0;
        end
    end

    // Normalise, range-check and pack the core result
    logic signed [EW-1:0] e_n;
    logic [MB-1:0]        frac_n;
    logic [N-1:0]         nm_res;
    logic [4:0]           nm_flg;

    always_comb begin
        e_n    = exp_q;
        frac_n = '0;
        nm_flg = flg_q;
        if (op_q) begin
            if (qm_q[QW-1]) begin
                frac_n = qm_q[QW-2 -: MB];
            end else begin
                frac_n = qm_q[MB-1:0];
                e_n    = exp_q - ONE_E;
            end
        end else begin
            if (acc_q[PW-1]) begin
                frac_n = acc_q[PW-2 -: MB];
                e_n    = exp_q + ONE_E;
            end else begin
                frac_n = acc_q[PW-3 -: MB];
            end
        end
        if (spec_q) begin
            nm_res = spec_res_q;
        end else if (e_n >= EMAX) begin
            nm_res    = {sign_q, {EB{1'b1}}, {MB{1'b0}}};
            nm_flg[2] = 1'b1;
        end else if (e_n < ONE_E) begin
            nm_res    = {sign_q, {(N-1){1'b0}}};
            nm_flg[1] = 1'b1;
        end else begin
            nm_res = {sign_q, e_n[EB-1:0], frac_n};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; special results still pass through NORM
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_i) state_d = S_LOAD;
            S_LOAD: state_d = ld_spec ? S_NORM : S_ITER;
            S_ITER: if (cnt_q == (op_q ? KDIV : KMUL)) state_d = S_NORM;
            S_NORM: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
    end

    // Datapath: capture, load, iterate, register result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            flg_q      <= '0;
            acc_q      <= '0;
            mcnd_q     <= '0;
            qm_q       <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            result_o   <= '0;
            flags_o    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q <= op_i;
                        a_q  <= a_i;
                        b_q  <= b_i;
                    end
                end
                S_LOAD: begin
                    cnt_q      <= '0;
                    flg_q      <= ld_flg;
                    spec_q     <= ld_spec;
                    spec_res_q <= ld_res;
                    sign_q     <= ld_sign;
                    exp_q      <= ld_exp;
                    acc_q      <= op_q ? PW'(ma) : '0;
                    mcnd_q     <= PW'(ma);
                    qm_q       <= op_q ? '0 : QW'(mb);
                    dvs_q      <= mb;
                end
                S_ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (op_q) begin
                        if (acc_q >= PW'(dvs_q)) begin
                            acc_q <= (acc_q - PW'(dvs_q)) << 1;
                            qm_q  <= {qm_q[QW-2:0], 1'b1};
                        end else begin
                            acc_q <= acc_q << 1;
                            qm_q  <= {qm_q[QW-2:0], 1'b0};
                        end
                    end else begin
                        if (qm_q[0]) acc_q <= acc_q + mcnd_q;
                        mcnd_q <= mcnd_q << 1;
                        qm_q   <= qm_q >> 1;
                    end
                end
                S_NORM: begin
                    result_o <= nm_res;
                    flags_o  <= nm_flg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_muldiv_seq_ctrl.sv
// Scoreboard bench for fp_muldiv_seq_ctrl.
// Directed vectors; a monitor checks result, flags and latency on done.
module tb_fp_muldiv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  flags;

    always #5 clk = ~clk;

    fp_muldiv_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .flags_o  (flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: compare against the oldest expectation whenever done is seen
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk({cur.name, "_result"}, result, cur.res);
                    chk({cur.name, "_flags"}, 32'(flags), 32'(cur.flg));
                    chk({cur.name, "_latency"}, 32'(cyc), 32'(cur.due));
                end
            end
        end
    end

    task automatic issue(input string nm, input logic o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [4:0] f,
                         input int lat, input bit push);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) sb.push_back('{r, f, cyc + 1 + lat, nm});
        @(negedge clk);
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run(input string nm, input logic o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic [4:0] f,
                       input int lat);
        issue(nm, o, x, y, r, f, lat, 1'b1);
        drain(nm);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", result,      32'd0);
        chk("rst_flags",  32'(flags),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("mul_3x2p5", 1'b0, 32'h40400000, 32'h40200000,
            32'h40F00000, 5'b00000, 26);
        run("div_1d3", 1'b1, 32'h3F800000, 32'h40400000,
            32'h3EAAAAAA, 5'b00000, 27);
        run("div_x0", 1'b1, 32'h40A00000, 32'h00000000,
            32'h7F800000, 5'b01000, 2);
        run("mul_inf0", 1'b0, 32'h7F800000, 32'h00000000,
            32'h7FFFFFFF, 5'b10000, 2);
        run("mul_ovf", 1'b0, 32'h7F000000, 32'h7F000000,
            32'h7F800000, 5'b00100, 26);
        run("mul_unf", 1'b0, 32'h00800000, 32'h00800000,
            32'h00000000, 5'b00010, 26);
        run("mul_den", 1'b0, 32'h00000001, 32'h40000000,
            32'h00000000, 5'b00001, 2);
        run("mul_sign", 1'b0, 32'hC0000000, 32'h40000000,
            32'hC0800000, 5'b00000, 26);

        // Start pulse during ITER must not disturb the op in flight
        issue("div_6d2", 1'b1, 32'h40C00000, 32'h40000000,
              32'h40400000, 5'b00000, 27, 1'b1);
        repeat (5) @(negedge clk);
        chk("busy_mid_iter", 32'(busy), 32'd1);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        drain("div_6d2");
        repeat (5) @(negedge clk);

        // Reset mid-op: outputs clear at once, no done afterwards
        issue("rst_op", 1'b0, 32'h3FC00000, 32'h3FC00000,
              32'h0, 5'b0, 26, 1'b0);
        repeat (8) @(negedge clk);
        chk("busy_pre_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy",   32'(busy),  32'd0);
        chk("rst_mid_result", result,     32'd0);
        chk("rst_mid_done",   32'(done),  32'd0);
        chk("rst_mid_flags",  32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        run("mul_1p5sq", 1'b0, 32'h3FC00000, 32'h3FC00000,
            32'h40100000, 5'b00000, 26);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
